alu_mc: RTL and testbench

- Parametrised multi-cycle ALU, successor to the single-cycle datapath ALU.
- Adds:
  - generic width
  - working LUI, SRA and SLL
  - iterative unsigned multiply/divide/remainder
  - valid/ready request handshake and registered result with done pulse
- Sits in the EX stage of the multi-cycle CPU; the control unit stalls on ready_o.

---
 rtl/alu_mc.sv | 199 +++++++++++++++++++
 tb/tb_alu_mc.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: parametrised multi-cycle ALU for the EX stage.
// Single-cycle logic/arith/shift ops finish in one cycle; MUL, DIVU and
// REMU iterate one bit per cycle on a shared shift/accumulate datapath.
// Results are registered and announced by a one-cycle done_o pulse.
module alu_mc #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  input  logic [SHAMT_W-1:0] shmat_i,
  input  logic [3:0]         ctrl_i,
  output logic [WIDTH-1:0]   result_o,
  output logic               zero_o,
  output logic               ovf_o,
  output logic               done_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_LUI  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_acc;   // MUL: partial product; DIVU/REMU: partial remainder
  logic [WIDTH-1:0] r_opa;   // MUL: shifted multiplicand; DIVU/REMU: dividend -> quotient
  logic [WIDTH-1:0] r_opb;   // MUL: shifted multiplier; DIVU/REMU: divisor

  logic w_accept;
  logic w_div0;
  logic w_iter;
  logic w_last;

  logic signed [WIDTH-1:0] w_src1_s;
  logic signed [WIDTH-1:0] w_src2_s;
  logic signed [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0]        w_sum;
  logic [WIDTH-1:0]        w_diff;
  logic [WIDTH-1:0]        w_sc_res;
  logic                    w_sc_ovf;

  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_rem_sub;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_opa_nxt;
  logic [WIDTH-1:0] w_opb_nxt;
  logic [WIDTH-1:0] w_it_res;

  assign w_accept = valid_i & ready_o;
  assign w_div0   = (src2_i == '0);
  // A zero divisor has a fixed answer, so it skips the iterative path.
  assign w_iter   = (ctrl_i == OP_MUL) ||
                    (((ctrl_i == OP_DIVU) || (ctrl_i == OP_REMU)) && !w_div0);
  assign w_last   = (r_state == S_BUSY) && (r_cnt == CNT_LAST);

  assign w_src1_s = $signed(src1_i);
  assign w_src2_s = $signed(src2_i);
  assign w_sra    = w_src2_s >>> shmat_i;
  assign w_sum    = src1_i + src2_i;
  assign w_diff   = src1_i - src2_i;

  // Single-cycle result and overflow, computed straight from the request inputs.
  always_comb begin
    w_sc_res = '0;
    w_sc_ovf = 1'b0;
    case (ctrl_i)
      OP_AND:  w_sc_res = src1_i & src2_i;
      OP_OR:   w_sc_res = src1_i | src2_i;
      OP_ADD: begin
        w_sc_res = w_sum;
        w_sc_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_SUB: begin
        w_sc_res = w_diff;
        w_sc_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                   (w_diff[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, (w_src1_s < w_src2_s)};
      OP_LUI:  w_sc_res = src2_i << (WIDTH / 2);
      OP_SRA:  w_sc_res = w_sra;
      OP_SLL:  w_sc_res = src2_i << shmat_i;
      OP_DIVU: w_sc_res = '1;       // only reached with a zero divisor
      OP_REMU: w_sc_res = src1_i;   // only reached with a zero divisor
      default: w_sc_res = '0;
    endcase
  end

  // One iteration step: shift-add for MUL, restoring step for DIVU/REMU.
  always_comb begin
    w_mul_acc = r_opb[0] ? (r_acc + r_opa) : r_acc;
    w_rem_sh  = {r_acc, r_opa[WIDTH-1]};
    w_rem_sub = w_rem_sh - {1'b0, r_opb};
    w_q_bit   = ~w_rem_sub[WIDTH];
    w_rem_nxt = w_q_bit ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    w_quo_nxt = {r_opa[WIDTH-2:0], w_q_bit};
    if (r_op == OP_MUL) begin
      w_acc_nxt = w_mul_acc;
      w_opa_nxt = r_opa << 1;
      w_opb_nxt = r_opb >> 1;
    end else begin
      w_acc_nxt = w_rem_nxt;
      w_opa_nxt = w_quo_nxt;
      w_opb_nxt = r_opb;
    end
    case (r_op)
      OP_MUL:  w_it_res = w_mul_acc;
      OP_DIVU: w_it_res = w_quo_nxt;
      default: w_it_res = w_rem_nxt;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state: IDLE/DONE accept requests, BUSY runs WIDTH iterations.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_state_nxt = w_iter ? S_BUSY : S_DONE;
        else          w_state_nxt = S_IDLE;
      end
      S_BUSY:  w_state_nxt = (r_cnt == CNT_LAST) ? S_DONE : S_BUSY;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: handshake ready and completion pulse.
  always_comb begin
    ready_o = (r_state != S_BUSY);
    done_o  = (r_state == S_DONE);
  end

  // Iteration counter, cleared on every accept.
  always_ff @(posedge clk_i) begin
    if (rst_i)                 r_cnt <= '0;
    else if (w_accept)         r_cnt <= '0;
    else if (r_state == S_BUSY) r_cnt <= r_cnt + 1'b1;
  end

  // Iterative datapath: capture operands on accept, step while BUSY.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_op  <= ctrl_i;
      r_acc <= '0;
      r_opa <= src1_i;
      r_opb <= src2_i;
    end else if (r_state == S_BUSY) begin
      r_acc <= w_acc_nxt;
      r_opa <= w_opa_nxt;
      r_opb <= w_opb_nxt;
    end
  end

  // Result registers, written only on the edge that enters DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_o <= '0;
      ovf_o    <= 1'b0;
    end else if (w_accept && !w_iter) begin
      result_o <= w_sc_res;
      ovf_o    <= w_sc_ovf;
    end else if (w_last) begin
      result_o <= w_it_res;
      ovf_o    <= 1'b0;
    end
  end

  assign zero_o = (result_o == '0);

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed-vector bench for alu_mc at WIDTH=32 and WIDTH=16.
module tb_alu_mc;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_LUI  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [31:0] src1, src2, result;
  logic [4:0]  shmat;
  logic [3:0]  ctrl;
  logic        zero, ovf, done;

  logic        v16;
  logic        rdy16;
  logic [15:0] a16, b16, res16;
  logic [3:0]  sh16;
  logic [3:0]  c16;
  logic        z16, ovf16, done16;

  int n_checks;
  int n_errors;
  int done_seen;

  alu_mc #(.WIDTH(32), .SHAMT_W(5), .CNT_W(6)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready),
    .src1_i(src1), .src2_i(src2), .shmat_i(shmat), .ctrl_i(ctrl),
    .result_o(result), .zero_o(zero), .ovf_o(ovf), .done_o(done)
  );

  alu_mc #(.WIDTH(16), .SHAMT_W(4), .CNT_W(5)) dut16 (
    .clk_i(clk), .rst_i(rst), .valid_i(v16), .ready_o(rdy16),
    .src1_i(a16), .src2_i(b16), .shmat_i(sh16), .ctrl_i(c16),
    .result_o(res16), .zero_o(z16), .ovf_o(ovf16), .done_o(done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request on the 32-bit DUT and wait (bounded) for done_o.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, output logic [31:0] res, output logic ov,
                        output logic z, output int lat, output int rdy_lo);
    ctrl = c; src1 = a; src2 = b; shmat = sh; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; ctrl = 4'hF; src1 = ~a; src2 = ~b; shmat = ~sh;
    lat = 0; rdy_lo = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (!ready) rdy_lo++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
    res = result; ov = ovf; z = zero;
    @(posedge clk); #1;
  endtask

  logic [31:0] r;
  logic        o, zz;
  int          lat, rl;

  initial begin
    n_checks = 0; n_errors = 0; done_seen = 0;
    rst = 1'b1; valid = 1'b0; src1 = '0; src2 = '0; shmat = '0; ctrl = '0;
    v16 = 1'b0; a16 = '0; b16 = '0; sh16 = '0; c16 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_result", result, 32'h0);
    check("rst_zero", {31'b0, zero}, 32'd1);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1;

    run_op(OP_ADD, 32'h7FFFFFFF, 32'h1, 5'd0, r, o, zz, lat, rl);
    check("add_res", r, 32'h80000000);
    check("add_ovf", {31'b0, o}, 32'd1);
    check("add_lat", lat, 32'd1);
    check("add_zero", {31'b0, zz}, 32'd0);

    run_op(OP_SUB, 32'd5, 32'd5, 5'd0, r, o, zz, lat, rl);
    check("sub_res", r, 32'h0);
    check("sub_zero", {31'b0, zz}, 32'd1);
    check("sub_ovf", {31'b0, o}, 32'd0);

    run_op(OP_SUB, 32'h80000000, 32'd1, 5'd0, r, o, zz, lat, rl);
    check("subov_res", r, 32'h7FFFFFFF);
    check("subov_ovf", {31'b0, o}, 32'd1);

    run_op(OP_SLT, 32'hFFFFFFFF, 32'd1, 5'd0, r, o, zz, lat, rl);
    check("slt_res", r, 32'd1);
    run_op(OP_SLT, 32'd1, 32'hFFFFFFFF, 5'd0, r, o, zz, lat, rl);
    check("slt_res2", r, 32'd0);

    run_op(OP_LUI, 32'hDEAD, 32'h1234, 5'd0, r, o, zz, lat, rl);
    check("lui_res", r, 32'h12340000);

    run_op(OP_AND, 32'h0000F0F0, 32'h0000FF00, 5'd0, r, o, zz, lat, rl);
    check("and_res", r, 32'h0000F000);
    run_op(OP_OR, 32'h0000F0F0, 32'h0000FF00, 5'd0, r, o, zz, lat, rl);
    check("or_res", r, 32'h0000FFF0);

    run_op(OP_SRA, 32'h0, 32'h80000000, 5'd4, r, o, zz, lat, rl);
    check("sra_res", r, 32'hF8000000);
    run_op(OP_SLL, 32'h0, 32'h1, 5'd31, r, o, zz, lat, rl);
    check("sll_res", r, 32'h80000000);
    run_op(OP_SLL, 32'h0, 32'hA5A51234, 5'd0, r, o, zz, lat, rl);
    check("sll0_res", r, 32'hA5A51234);
    run_op(OP_SRA, 32'h0, 32'hA5A51234, 5'd0, r, o, zz, lat, rl);
    check("sra0_res", r, 32'hA5A51234);

    run_op(OP_MUL, 32'h00010000, 32'h00010001, 5'd0, r, o, zz, lat, rl);
    check("mul_res", r, 32'h00010000);
    check("mul_lat", lat, 32'd33);
    check("mul_rdy_lo", rl, 32'd32);
    check("mul_ovf", {31'b0, o}, 32'd0);
    @(negedge clk);
    check("mul_pulse", {31'b0, done}, 32'd0);
    @(posedge clk); #1;

    run_op(OP_DIVU, 32'd100, 32'd7, 5'd0, r, o, zz, lat, rl);
    check("divu_res", r, 32'd14);
    check("divu_lat", lat, 32'd33);
    run_op(OP_REMU, 32'd100, 32'd7, 5'd0, r, o, zz, lat, rl);
    check("remu_res", r, 32'd2);
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'd3, 5'd0, r, o, zz, lat, rl);
    check("divu_big", r, 32'h55555555);

    run_op(OP_DIVU, 32'd9, 32'd0, 5'd0, r, o, zz, lat, rl);
    check("div0_res", r, 32'hFFFFFFFF);
    check("div0_lat", lat, 32'd1);
    run_op(OP_REMU, 32'd9, 32'd0, 5'd0, r, o, zz, lat, rl);
    check("rem0_res", r, 32'd9);
    check("rem0_lat", lat, 32'd1);

    run_op(4'b1111, 32'd9, 32'd3, 5'd0, r, o, zz, lat, rl);
    check("undef_res", r, 32'd0);
    check("undef_zero", {31'b0, zz}, 32'd1);

    // valid_i held high through BUSY with different operands must be ignored
    ctrl = OP_MUL; src1 = 32'd3; src2 = 32'd5; valid = 1'b1;
    @(posedge clk); #1;
    ctrl = OP_ADD; src1 = 32'd1; src2 = 32'd1;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (done) begin valid = 1'b0; break; end
    end
    valid = 1'b0;
    check("busy_lat", lat, 32'd33);
    check("busy_res", result, 32'd15);
    @(posedge clk); #1;
    @(negedge clk);
    check("busy_noextra", {31'b0, done}, 32'd0);
    @(posedge clk); #1;

    // back-to-back: ADD accepted in the DONE cycle of a DIVU
    ctrl = OP_DIVU; src1 = 32'd100; src2 = 32'd7; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    check("b2b_div_lat", lat, 32'd33);
    check("b2b_div_res", result, 32'd14);
    ctrl = OP_ADD; src1 = 32'd40; src2 = 32'd2; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    check("b2b_add_done", {31'b0, done}, 32'd1);
    check("b2b_add_res", result, 32'd42);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_idle", {31'b0, done}, 32'd0);
    @(posedge clk); #1;

    // reset for 2 cycles in the middle of a MUL
    run_op(OP_ADD, 32'd1, 32'd2, 5'd0, r, o, zz, lat, rl);
    check("pre_rst_res", r, 32'd3);
    ctrl = OP_MUL; src1 = 32'd7; src2 = 32'd9; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    done_seen = 0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_result", result, 32'h0);
    check("mrst_zero", {31'b0, zero}, 32'd1);
    check("mrst_ready", {31'b0, ready}, 32'd1);
    repeat (40) @(negedge clk);
    check("mrst_no_done", done_seen, 32'd0);
    @(posedge clk); #1;

    // WIDTH=16: MUL 300*300, then back-to-back ADD with overflow
    c16 = OP_MUL; a16 = 16'd300; b16 = 16'd300; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (done16) break;
    end
    check("w16_mul_lat", lat, 32'd17);
    check("w16_mul_res", {16'b0, res16}, 32'h5F90);
    c16 = OP_ADD; a16 = 16'h7FFF; b16 = 16'h0001; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    @(negedge clk);
    check("w16_add_done", {31'b0, done16}, 32'd1);
    check("w16_add_res", {16'b0, res16}, 32'h8000);
    check("w16_add_ovf", {31'b0, ovf16}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("w16_idle", {31'b0, done16}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
